// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision constants and enums for the float front/back ends.
package ieee754_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  // Width of signed exponent/shift arithmetic; roomy enough for any sane FRAC_LEN.
  localparam int unsigned SH_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StShift,
    StRound,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsNan
  } float_cls_e;

endpackage

// File: rtl/ieee754_unpack.sv
// Combinational IEEE-754 single field split, classification and fixed-point shift amount.
module ieee754_unpack
  import ieee754_pkg::*;
#(
  parameter int unsigned FRAC_LEN = 8
) (
  input  logic [31:0]            ieee_in,
  output logic                   sign,
  output float_cls_e             cls,
  output logic                   man_nz,
  output logic [MAN_W:0]         mag,
  output logic signed [SH_W-1:0] e,
  output logic signed [SH_W-1:0] sh
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign {sign, exp_f, man_f} = ieee_in;
  assign man_nz = |man_f;
  assign mag    = {1'b1, man_f};
  assign e      = $signed(SH_W'(exp_f)) - $signed(SH_W'(EXP_BIAS));
  // Positive sh means the hidden-one mantissa must move left to land on the binary point.
  assign sh     = e + $signed(SH_W'(FRAC_LEN)) - $signed(SH_W'(MAN_W));

  always_comb begin
    if (exp_f == EXP_SPECIAL) begin
      cls = man_nz ? ClsNan : ClsInf;
    end else if (exp_f == '0) begin
      cls = ClsZero;
    end else begin
      cls = ClsNorm;
    end
  end

endmodule

// File: rtl/ieee754_to_fixed_seq.sv
// Iterative IEEE-754 single -> signed Q(INT_LEN).(FRAC_LEN) converter, one bit shifted per cycle.
module ieee754_to_fixed_seq
  import ieee754_pkg::*;
#(
  parameter int unsigned INT_LEN  = 16,
  parameter int unsigned FRAC_LEN = 8,
  parameter bit          ROUND_EN = 1'b1,
  localparam int unsigned W = INT_LEN + FRAC_LEN
) (
  input  logic         clk_100k,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  ieee_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] fixed_out,
  output logic         ovf,
  output logic         unf,
  output logic         nan
);

  localparam int unsigned AW = ((W > MAN_W + 1) ? W : MAN_W + 1) + 1;
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [AW-1:0] MAG_MAX = AW'(SAT_POS);
  localparam logic signed [SH_W-1:0] E_SAT  = SH_W'(INT_LEN - 1);
  localparam logic signed [SH_W-1:0] SH_MIN = SH_W'(-25);

  state_e state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            g_q, g_d, s_q, s_d;
  logic [SH_W-1:0] cnt_q, cnt_d;
  logic            left_q, left_d, sign_q, sign_d, bypass_q, bypass_d;
  logic [W-1:0]    fixed_q, fixed_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d;

  logic                   u_sign, u_man_nz;
  float_cls_e             u_cls;
  logic [MAN_W:0]         u_mag;
  logic signed [SH_W-1:0] u_e, u_sh;

  ieee754_unpack #(
    .FRAC_LEN(FRAC_LEN)
  ) u_unpack (
    .ieee_in(word_q),
    .sign   (u_sign),
    .cls    (u_cls),
    .man_nz (u_man_nz),
    .mag    (u_mag),
    .e      (u_e),
    .sh     (u_sh)
  );

  logic            is_special, is_big, is_tiny, need_shift;
  logic [SH_W-1:0] sh_abs;

  assign is_special = (u_cls != ClsNorm);
  assign is_big     = (u_e >= E_SAT);
  assign is_tiny    = (u_sh < SH_MIN);
  assign need_shift = !is_special && !is_big && !is_tiny && (u_sh != '0);
  assign sh_abs     = u_sh[SH_W-1] ? SH_W'(-u_sh) : u_sh;

  // Round-half-even on magnitude, or floor of the signed value when rounding is disabled.
  logic          inc;
  logic [AW-1:0] mag_r, mag_lim;

  assign inc     = ROUND_EN ? (g_q & (s_q | acc_q[0])) : (sign_q & (g_q | s_q));
  assign mag_r   = acc_q + AW'(inc);
  assign mag_lim = MAG_MAX + AW'(sign_q);

  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUnpack;
      StUnpack: state_d = need_shift ? StShift : StRound;
      StShift:  if (cnt_q == SH_W'(1)) state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    word_d   = word_q;
    acc_d    = acc_q;
    g_d      = g_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sign_d   = sign_q;
    bypass_d = bypass_q;
    fixed_d  = fixed_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    nan_d    = nan_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d = ieee_in;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          nan_d  = 1'b0;
        end
      end
      StUnpack: begin
        sign_d   = u_sign;
        acc_d    = AW'(u_mag);
        g_d      = 1'b0;
        s_d      = 1'b0;
        cnt_d    = sh_abs;
        left_d   = !u_sh[SH_W-1];
        bypass_d = 1'b1;
        if (u_cls == ClsNan) begin
          fixed_d = '0;
          nan_d   = 1'b1;
        end else if (u_cls == ClsInf || (u_cls == ClsNorm && is_big)) begin
          fixed_d = u_sign ? SAT_NEG : SAT_POS;
          ovf_d   = 1'b1;
        end else if (u_cls == ClsZero) begin
          fixed_d = '0;
          unf_d   = u_man_nz;
        end else begin
          bypass_d = 1'b0;
          // Everything lands below the sticky bit: pure sticky, rounds to zero.
          if (is_tiny) begin
            acc_d = '0;
            s_d   = 1'b1;
          end
        end
      end
      StShift: begin
        cnt_d = cnt_q - SH_W'(1);
        if (left_q) begin
          acc_d = acc_q << 1;
        end else begin
          acc_d = acc_q >> 1;
          g_d   = acc_q[0];
          s_d   = s_q | g_q;
        end
      end
      StRound: begin
        if (!bypass_q) begin
          if (mag_r > mag_lim) begin
            fixed_d = sign_q ? SAT_NEG : SAT_POS;
            ovf_d   = 1'b1;
          end else begin
            fixed_d = sign_q ? (W'(0) - mag_r[W-1:0]) : mag_r[W-1:0];
            unf_d   = (mag_r == '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      word_q   <= '0;
      acc_q    <= '0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      bypass_q <= 1'b0;
      fixed_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      acc_q    <= acc_d;
      g_q      <= g_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      bypass_q <= bypass_d;
      fixed_q  <= fixed_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nan_q    <= nan_d;
    end
  end

  assign fixed_out = fixed_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign nan       = nan_q;

endmodule

// File: tb/tb_ieee754_to_fixed_seq.sv
// Directed + randomized bench for ieee754_to_fixed_seq against an exact-arithmetic model.
module tb_ieee754_to_fixed_seq;

  localparam int unsigned W = 24;

  logic         clk_100k = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  ieee_in = '0;
  logic         in_ready, out_valid, ovf, unf, nan;
  logic [W-1:0] fixed_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_100k = ~clk_100k;

  ieee754_to_fixed_seq #(
    .INT_LEN (16),
    .FRAC_LEN(8),
    .ROUND_EN(1'b1)
  ) dut (
    .clk_100k (clk_100k),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ieee_in  (ieee_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fixed_out(fixed_out),
    .ovf      (ovf),
    .unf      (unf),
    .nan      (nan)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100k);
    #1;
  endtask

  // Exact value model: fixed = (-1)^s * mant * 2^(e-15), rounded half-even, saturated.
  task automatic model(input logic [31:0] w, output logic [W-1:0] f, output logic o,
                       output logic u, output logic n, output int lat);
    int e, k;
    longint mant, q, rem, half;
    logic sg;
    logic [7:0] ex;
    logic [22:0] mn;
    sg = w[31];
    ex = w[30:23];
    mn = w[22:0];
    e = int'(ex) - 127;
    mant = longint'({1'b1, mn});
    f = '0; o = 1'b0; u = 1'b0; n = 1'b0; lat = 2;
    q = 0;
    if (ex == 8'hFF && mn != 0) begin
      n = 1'b1;
    end else if (ex == 8'hFF) begin
      o = 1'b1;
      f = sg ? 24'h800000 : 24'h7FFFFF;
    end else if (ex == 8'h00) begin
      u = (mn != 0);
    end else if (e >= 15) begin
      o = 1'b1;
      f = sg ? 24'h800000 : 24'h7FFFFF;
    end else begin
      k = e + 8 - 23;
      if (k >= -25) lat = 2 + ((k < 0) ? -k : k);
      if (k >= 0) begin
        q = mant <<< k;
      end else if (k < -40) begin
        q = 0;
      end else begin
        q = mant >>> (-k);
        rem = mant - (q <<< (-k));
        half = longint'(1) <<< (-k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q > (sg ? 64'sd8388608 : 64'sd8388607)) begin
        o = 1'b1;
        f = sg ? 24'h800000 : 24'h7FFFFF;
      end else begin
        f = sg ? 24'(-q) : 24'(q);
        u = (q == 0);
      end
    end
  endtask

  task automatic convert(input logic [31:0] w, input logic [W-1:0] ef, input logic eo,
                         input logic eu, input logic en, input int elat, input int hold);
    int n;
    in_valid = 1'b1;
    ieee_in = w;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("in_ready_idle[%08h]", w), in_ready, 1);
    tick();
    in_valid = 1'b0;
    ieee_in = $urandom;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("latency[%08h]", w), n, elat);
    check($sformatf("in_ready_busy[%08h]", w), in_ready, 0);
    check($sformatf("fixed[%08h]", w), fixed_out, ef);
    check($sformatf("flags[%08h]", w), {ovf, unf, nan}, {eo, eu, en});
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      ieee_in = $urandom;
      tick();
      check($sformatf("hold_state[%08h]", w), {out_valid, in_ready}, 2'b10);
      check($sformatf("hold_data[%08h]", w), {fixed_out, ovf, unf, nan}, {ef, eo, eu, en});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("after_hs[%08h]", w), {out_valid, in_ready}, 2'b01);
  endtask

  task automatic convert_rand(input logic [31:0] w, input int hold);
    logic [W-1:0] f;
    logic o, u, n;
    int lat;
    model(w, f, o, u, n, lat);
    convert(w, f, o, u, n, lat, hold);
  endtask

  initial begin
    logic [31:0] w;
    int sel;
    #1;
    check("reset_state", {in_ready, out_valid, fixed_out, ovf, unf, nan}, {2'b10, 24'h0, 3'b000});
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    convert(32'h3F800000, 24'h000100, 0, 0, 0, 17, 0);
    convert(32'hC0200000, 24'hFFFD80, 0, 0, 0, 16, 5);
    convert(32'h47000000, 24'h7FFFFF, 1, 0, 0, 2, 0);
    convert(32'hFF800000, 24'h800000, 1, 0, 0, 2, 1);
    convert(32'h7FC00000, 24'h000000, 0, 0, 1, 2, 0);
    convert(32'h00000001, 24'h000000, 0, 1, 0, 2, 0);
    convert(32'h3B800000, 24'h000001, 0, 0, 0, 25, 0);
    convert(32'h3B000000, 24'h000000, 0, 1, 0, 26, 0);
    convert(32'h3BC00000, 24'h000002, 0, 0, 0, 25, 0);
    convert(32'h80000000, 24'h000000, 0, 0, 0, 2, 0);
    convert(32'hC7000000, 24'h800000, 1, 0, 0, 2, 0);
    convert(32'h46FFFE00, 24'h7FFF00, 0, 0, 0, 3, 0);
    convert(32'h46FFFFFF, 24'h7FFFFF, 1, 0, 0, 3, 0);
    convert(32'hC6FFFFFF, 24'h800000, 0, 0, 0, 3, 0);

    // Abort a conversion of 1.0 while it is shifting.
    in_valid = 1'b1;
    ieee_in = 32'h3F800000;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("reset_mid_shift", {in_ready, out_valid, fixed_out, ovf, unf, nan},
          {2'b10, 24'h0, 3'b000});
    tick();
    reset_n = 1'b1;
    tick();
    convert(32'h40000000, 24'h000200, 0, 0, 0, 16, 0);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        w = $urandom;
      end else begin
        w = {1'($urandom), 8'($urandom_range(95, 146)), 23'($urandom)};
      end
      convert_rand(w, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
